// File: rtl/lane_deskew_pkg.sv
// Shared types and defaults for the per-lane deskew buffer.
// Pulled in by the interface, the RAM and the top.
package lane_deskew_pkg;

  localparam int unsigned NB_CODED_BLOCK_DEF = 66;
  localparam int unsigned MAX_SKEW_DEF       = 63;
  localparam int unsigned NB_DELAY_DEF       = $clog2(MAX_SKEW_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOL,
    COUNT,
    ALIGNED,
    SKEW_ERR
  } deskew_state_t;

endpackage

// File: rtl/lane_deskew_buffer_if.sv
// Block stream and status bundle for one lane's deskew stage.
// The slave modport is the deskew stage; master is its upstream/downstream side.
interface lane_deskew_buffer_if
  import lane_deskew_pkg::*;
#(
  parameter int unsigned NB_CODED_BLOCK = NB_CODED_BLOCK_DEF,
  parameter int unsigned NB_DELAY       = NB_DELAY_DEF
);
  logic                      i_enable;
  logic                      i_valid;
  logic [NB_CODED_BLOCK-1:0] i_data;
  logic                      i_am_lock;
  logic                      i_resync;
  logic                      i_start_of_lane;
  logic                      i_all_lanes_sol;
  logic [NB_CODED_BLOCK-1:0] o_data;
  logic [NB_DELAY-1:0]       o_delay;
  logic                      o_sol_seen;
  logic                      o_deskew_done;
  logic                      o_skew_error;

  modport master (
    output i_enable, i_valid, i_data, i_am_lock, i_resync, i_start_of_lane, i_all_lanes_sol,
    input  o_data, o_delay, o_sol_seen, o_deskew_done, o_skew_error
  );

  modport slave (
    input  i_enable, i_valid, i_data, i_am_lock, i_resync, i_start_of_lane, i_all_lanes_sol,
    output o_data, o_delay, o_sol_seen, o_deskew_done, o_skew_error
  );
endinterface

// File: rtl/lane_deskew_buffer_ram.sv
// Simple dual-port block buffer: synchronous write, asynchronous read.
// A read in the same cycle as a write to that address returns the old entry.
module deskew_ram
  import lane_deskew_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_CODED_BLOCK_DEF,
  parameter int unsigned NB_ADDR = NB_DELAY_DEF
) (
  input  logic               i_clock,
  input  logic               i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);
  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem[i_rd_addr];
endmodule

// File: rtl/lane_deskew_buffer.sv
// Per-lane deskew: measures how many blocks this lane's SOL leads the last
// lane's SOL and delays the block stream by that amount.
module lane_deskew_buffer
  import lane_deskew_pkg::*;
#(
  parameter int unsigned NB_CODED_BLOCK = NB_CODED_BLOCK_DEF,
  parameter int unsigned MAX_SKEW       = MAX_SKEW_DEF,
  parameter int unsigned NB_DELAY       = $clog2(MAX_SKEW + 1)
) (
  input logic                 i_clock,
  input logic                 i_reset,
  lane_deskew_buffer_if.slave bus
);
  localparam logic [NB_DELAY-1:0] MAX_CNT = NB_DELAY'(MAX_SKEW);

  deskew_state_t             state_q, state_d;
  logic [NB_DELAY-1:0]       cnt_q, cnt_d;
  logic [NB_DELAY-1:0]       delay_q, delay_d;
  logic                      sol_q, sol_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [NB_DELAY-1:0]       wr_ptr_q;
  logic [NB_CODED_BLOCK-1:0] data_q;
  logic [NB_CODED_BLOCK-1:0] rd_data;
  logic                      ev;

  assign ev = bus.i_enable & bus.i_valid;

  deskew_ram #(
    .NB_DATA (NB_CODED_BLOCK),
    .NB_ADDR (NB_DELAY)
  ) u_ram (
    .i_clock   (i_clock),
    .i_wr_en   (ev),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (bus.i_data),
    .i_rd_addr (wr_ptr_q - delay_q),
    .o_rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    sol_d   = sol_q;
    done_d  = done_q;
    err_d   = err_q;
    // Lock loss / resync outrank everything, so a SOL coinciding with resync is dropped.
    if ((state_q != IDLE) && (!bus.i_am_lock || bus.i_resync)) begin
      state_d = bus.i_am_lock ? WAIT_SOL : IDLE;
      cnt_d   = '0;
      delay_d = '0;
      sol_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_am_lock) state_d = WAIT_SOL;
        end
        WAIT_SOL: begin
          if (bus.i_start_of_lane) begin
            sol_d = 1'b1;
            if (bus.i_all_lanes_sol) begin
              delay_d = '0;
              done_d  = 1'b1;
              state_d = ALIGNED;
            end else begin
              cnt_d   = NB_DELAY'(1);
              state_d = COUNT;
            end
          end
        end
        COUNT: begin
          if (bus.i_all_lanes_sol) begin
            delay_d = cnt_q;
            done_d  = 1'b1;
            state_d = ALIGNED;
          end else if (cnt_q == MAX_CNT) begin
            err_d   = 1'b1;
            state_d = SKEW_ERR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      delay_q  <= '0;
      sol_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      data_q   <= '0;
    end else if (ev) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
      sol_q    <= sol_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_q + 1'b1;
      data_q   <= (delay_q == '0) ? bus.i_data : rd_data;
    end
  end

  assign bus.o_data        = data_q;
  assign bus.o_delay       = delay_q;
  assign bus.o_sol_seen    = sol_q;
  assign bus.o_deskew_done = done_q;
  assign bus.o_skew_error  = err_q;
endmodule

// File: tb/tb_lane_deskew_buffer.sv
// Directed self-checking bench for lane_deskew_buffer with an o_data scoreboard
// built from the history of blocks sent on valid cycles.
module tb_lane_deskew_buffer;
  localparam int unsigned NB  = 66;
  localparam int unsigned NBD = 6;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clock = ~i_clock;

  lane_deskew_buffer_if #(.NB_CODED_BLOCK(NB), .NB_DELAY(NBD)) bus ();

  lane_deskew_buffer #(
    .NB_CODED_BLOCK (NB),
    .MAX_SKEW       (63),
    .NB_DELAY       (NBD)
  ) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [NB-1:0] hist[$];
  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] last_exp = '0;

  function automatic logic [NB-1:0] rnd();
    return {$urandom(), $urandom(), 2'($urandom_range(3))};
  endfunction

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // One valid block; when chkd, scoreboard expects the block sent dly valid cycles earlier.
  task automatic ev(input logic lock, input logic rs, input logic sol, input logic asol,
                    input bit chkd, input int dly);
    logic [NB-1:0] d;
    logic [NB-1:0] e;
    bit pushed;
    d = rnd();
    pushed = 1'b0;
    bus.i_enable        = 1'b1;
    bus.i_valid         = 1'b1;
    bus.i_data          = d;
    bus.i_am_lock       = lock;
    bus.i_resync        = rs;
    bus.i_start_of_lane = sol;
    bus.i_all_lanes_sol = asol;
    if (chkd && hist.size() >= dly) begin
      exp_q.push_back((dly == 0) ? d : hist[hist.size() - dly]);
      pushed = 1'b1;
    end
    hist.push_back(d);
    tick();
    bus.i_valid         = 1'b0;
    bus.i_resync        = 1'b0;
    bus.i_start_of_lane = 1'b0;
    bus.i_all_lanes_sol = 1'b0;
    if (pushed) begin
      e = exp_q.pop_front();
      last_exp = e;
      chk("o_data", bus.o_data, e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_valid = 1'b0;
      bus.i_data  = rnd();
      bus.i_start_of_lane = 1'($urandom_range(1));
      bus.i_all_lanes_sol = 1'($urandom_range(1));
      tick();
    end
    bus.i_start_of_lane = 1'b0;
    bus.i_all_lanes_sol = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input int dly, input bit sol, input bit done, input bit err);
    chk({tag, ".delay"}, NB'(bus.o_delay), NB'(dly));
    chk({tag, ".sol_seen"}, NB'(bus.o_sol_seen), NB'(sol));
    chk({tag, ".done"}, NB'(bus.o_deskew_done), NB'(done));
    chk({tag, ".skew_err"}, NB'(bus.o_skew_error), NB'(err));
  endtask

  initial begin
    bus.i_enable = 1'b1; bus.i_valid = 1'b0; bus.i_data = '0; bus.i_am_lock = 1'b0;
    bus.i_resync = 1'b0; bus.i_start_of_lane = 1'b0; bus.i_all_lanes_sol = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    chk("rst.data", bus.o_data, '0);
    chk_flags("rst", 0, 0, 0, 0);

    // Reset while counting (counter reaches 5)
    ev(1, 0, 0, 0, 1, 0);
    ev(1, 0, 1, 0, 1, 0);
    chk_flags("count", 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) ev(1, 0, 0, 0, 1, 0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    hist.delete();
    chk("midrst.data", bus.o_data, '0);
    chk_flags("midrst", 0, 0, 0, 0);

    // Lock with SOL and all_sol together -> zero delay
    ev(1, 0, 1, 1, 1, 0);
    ev(1, 0, 1, 1, 1, 0);
    chk_flags("zero_skew", 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) ev(1, 0, 0, 0, 1, 0);

    // Resync then 7-block skew
    ev(1, 1, 0, 0, 1, 0);
    chk_flags("resync", 0, 0, 0, 0);
    ev(1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) ev(1, 0, 0, 0, 1, 0);
    ev(1, 0, 0, 1, 1, 0);
    chk_flags("skew7", 7, 1, 1, 0);
    for (int i = 0; i < 10; i++) ev(1, 0, 0, 0, 1, 7);
    ev(1, 0, 1, 1, 1, 7);
    chk_flags("aligned_hold", 7, 1, 1, 0);
    for (int i = 0; i < 10; i++) ev(1, 0, 0, 0, 1, 7);

    // Lock loss while aligned
    ev(0, 0, 0, 0, 1, 7);
    chk_flags("unlock", 0, 0, 0, 0);

    // Skew overflow at the 63rd block after SOL
    ev(1, 0, 0, 0, 1, 0);
    ev(1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 62; i++) ev(1, 0, 0, 0, 1, 0);
    chk_flags("pre_err", 0, 1, 0, 0);
    ev(1, 0, 0, 0, 1, 0);
    chk_flags("skew_err", 0, 1, 0, 1);
    ev(1, 0, 1, 1, 1, 0);
    chk_flags("err_hold", 0, 1, 0, 1);
    ev(1, 1, 0, 0, 1, 0);
    chk_flags("err_resync", 0, 0, 0, 0);
    ev(1, 0, 1, 1, 1, 0);
    chk_flags("err_wait_sol", 0, 1, 1, 0);

    // Sparse valid: 3-block skew across 12 clocks
    ev(1, 1, 0, 0, 1, 0);
    idle(3);
    ev(1, 0, 1, 0, 1, 0);
    idle(3);
    ev(1, 0, 0, 0, 1, 0);
    idle(3);
    ev(1, 0, 0, 0, 1, 0);
    idle(3);
    ev(1, 0, 0, 1, 1, 0);
    chk_flags("sparse", 3, 1, 1, 0);
    for (int i = 0; i < 12; i++) begin
      idle(3);
      ev(1, 0, 0, 0, 1, 3);
    end

    // all_sol before own SOL is ignored; SOL coinciding with resync is discarded
    ev(1, 1, 0, 0, 1, 3);
    ev(1, 0, 0, 1, 1, 0);
    chk_flags("early_allsol", 0, 0, 0, 0);
    ev(1, 1, 1, 0, 1, 0);
    chk_flags("resync_sol", 0, 0, 0, 0);
    ev(1, 0, 0, 1, 1, 0);
    chk_flags("still_wait", 0, 0, 0, 0);
    ev(1, 0, 1, 0, 1, 0);
    chk_flags("sol_after", 0, 1, 0, 0);

    // Enable low freezes everything
    bus.i_enable = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data = rnd();
    bus.i_all_lanes_sol = 1'b1;
    bus.i_resync = 1'b0;
    tick(); tick();
    bus.i_all_lanes_sol = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_enable = 1'b1;
    chk("freeze.data", bus.o_data, last_exp);
    chk_flags("freeze", 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
